mem_bus_responder: RTL and testbench

MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

---
 rtl/mem_bus_responder.sv | 90 +++++++++
 tb/tb_mem_bus_responder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: 256x16 word memory with program-load port and a fixed-latency rd/wr handshake
module mem_bus_responder #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_memory_addr,
  input  logic [15:0] i_memory_data,
  output logic [15:0] o_memory_data,
  input  logic        i_rd_req,
  input  logic        i_wr_req,
  output logic        o_mem_ready,
  output logic        o_busy,
  output logic        o_bus_err,
  input  logic        i_load_en,
  input  logic [7:0]  i_load_addr,
  input  logic [15:0] i_load_data,
  input  logic        i_load_done,
  output logic        o_cpu_start
);
  typedef enum logic [1:0] {IDLE = 2'd0, RD_WAIT = 2'd1, WR_WAIT = 2'd2} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic        start_q, start_d;
  logic [15:0] mem [256];
  logic        accept;
  logic        done;
  logic        mem_we;
  logic [7:0]  mem_waddr;
  logic [15:0] mem_wdata;
  // All control/status flops; the memory array is kept out so reset never touches it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 8'd0;
      wdata_q <= 16'd0;
      rdata_q <= 16'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      start_q <= start_d;
    end
  end
  // Next state: requests only accepted in run phase while idle; write wins a collision
  always_comb begin
    state_d = (state_q == IDLE) ? (!start_q ? IDLE : i_wr_req ? WR_WAIT : i_rd_req ? RD_WAIT : IDLE)
            : (cnt_q == 4'd0) ? IDLE : state_q;
  end
  // Datapath: capture on accept, count down, complete when the counter has reached zero
  always_comb begin
    accept    = (state_q == IDLE) && start_q && (i_rd_req || i_wr_req);
    done      = (state_q != IDLE) && (cnt_q == 4'd0);
    cnt_d     = accept ? 4'(WAIT_CYCLES) : (state_q != IDLE && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    addr_d    = accept ? i_memory_addr : addr_q;
    wdata_d   = accept ? i_memory_data : wdata_q;
    rdata_d   = (done && state_q == RD_WAIT) ? mem[addr_q] : rdata_q;
    ready_d   = done;
    err_d     = (state_q == IDLE) && start_q && i_rd_req && i_wr_req;
    start_d   = start_q | i_load_done;
    mem_we    = i_rst_n && (!start_q ? i_load_en : (done && state_q == WR_WAIT));
    mem_waddr = !start_q ? i_load_addr : addr_q;
    mem_wdata = !start_q ? i_load_data : wdata_q;
  end
  // Single write port shared by program load and run-phase writes
  always_ff @(posedge i_clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end
  // Outputs straight from registers
  always_comb begin
    o_memory_data = rdata_q;
    o_mem_ready   = ready_q;
    o_busy        = state_q != IDLE;
    o_bus_err     = err_q;
    o_cpu_start   = start_q;
  end
endmodule

// File: tb/tb_mem_bus_responder.sv
// tb_mem_bus_responder: table-driven and randomized checks against a word-array reference model
module tb_mem_bus_responder;
  localparam int W = 2;
  logic        clk = 1'b0;
  logic        i_rst_n;
  logic [7:0]  i_memory_addr;
  logic [15:0] i_memory_data;
  logic        i_rd_req, i_wr_req, rd0, wr0;
  logic        i_load_en, i_load_done;
  logic [7:0]  i_load_addr;
  logic [15:0] i_load_data;
  logic [15:0] o_memory_data, rdata0;
  logic        o_mem_ready, o_busy, o_bus_err, o_cpu_start;
  logic        ready0, busy0, err0, start0;
  int          errors = 0;
  int          checks = 0;
  logic [15:0] model_mem [256];
  logic [15:0] model_rdata;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [7:0]  addr;
    logic [15:0] data;
    logic [15:0] exp_rdata;
  } vec_t;
  vec_t tbl [6];

  always #5 clk = ~clk;

  mem_bus_responder #(.WAIT_CYCLES(W)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_memory_addr(i_memory_addr), .i_memory_data(i_memory_data),
    .o_memory_data(o_memory_data), .i_rd_req(i_rd_req), .i_wr_req(i_wr_req), .o_mem_ready(o_mem_ready),
    .o_busy(o_busy), .o_bus_err(o_bus_err), .i_load_en(i_load_en), .i_load_addr(i_load_addr),
    .i_load_data(i_load_data), .i_load_done(i_load_done), .o_cpu_start(o_cpu_start));

  mem_bus_responder #(.WAIT_CYCLES(0)) dut0 (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_memory_addr(i_memory_addr), .i_memory_data(i_memory_data),
    .o_memory_data(rdata0), .i_rd_req(rd0), .i_wr_req(wr0), .o_mem_ready(ready0),
    .o_busy(busy0), .o_bus_err(err0), .i_load_en(i_load_en), .i_load_addr(i_load_addr),
    .i_load_data(i_load_data), .i_load_done(i_load_done), .o_cpu_start(start0));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load(input logic en, input logic [7:0] a, input logic [15:0] d, input logic dn);
    @(negedge clk);
    i_load_en = en; i_load_addr = a; i_load_data = d; i_load_done = dn;
    @(negedge clk);
    i_load_en = 1'b0; i_load_done = 1'b0;
  endtask

  task automatic do_txn(input logic rd, input logic wr, input logic [7:0] a, input logic [15:0] d);
    logic [15:0] exp_rd, old_rd;
    @(negedge clk);
    chk("idle_ready", o_mem_ready, 0);
    chk("idle_busy", o_busy, 0);
    i_rd_req = rd; i_wr_req = wr; i_memory_addr = a; i_memory_data = d;
    old_rd = model_rdata;
    exp_rd = (rd && !wr) ? model_mem[a] : model_rdata;
    if (wr) model_mem[a] = d;
    model_rdata = exp_rd;
    for (int k = 0; k <= W + 1; k++) begin
      @(negedge clk);
      chk("busy", o_busy, 32'(k <= W));
      chk("ready", o_mem_ready, 32'(k == W + 1));
      chk("bus_err", o_bus_err, 32'(k == 0 && rd && wr));
      if (k == W + 1) begin
        chk("rdata", o_memory_data, exp_rd);
        i_rd_req = 1'b0; i_wr_req = 1'b0;
      end else begin
        chk("rdata_hold", o_memory_data, old_rd);
        i_rd_req = 1'($urandom); i_wr_req = 1'($urandom);
        i_memory_addr = 8'($urandom); i_memory_data = 16'($urandom);
      end
    end
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 8'h00, 16'h0000, 16'h1234};
    tbl[1] = '{1'b0, 1'b1, 8'h10, 16'hA5A5, 16'h1234};
    tbl[2] = '{1'b1, 1'b0, 8'h10, 16'h0000, 16'hA5A5};
    tbl[3] = '{1'b1, 1'b1, 8'h20, 16'h0F0F, 16'hA5A5};
    tbl[4] = '{1'b1, 1'b0, 8'h20, 16'h0000, 16'h0F0F};
    tbl[5] = '{1'b1, 1'b0, 8'hFF, 16'h0000, 16'hBEEF};
    i_rst_n = 1'b0; i_rd_req = 1'b0; i_wr_req = 1'b0; rd0 = 1'b0; wr0 = 1'b0;
    i_memory_addr = 8'h00; i_memory_data = 16'h0000;
    i_load_en = 1'b0; i_load_addr = 8'h00; i_load_data = 16'h0000; i_load_done = 1'b0;
    model_rdata = 16'h0000;
    #1;
    chk("rst_rdata", o_memory_data, 0);
    chk("rst_ready", o_mem_ready, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_err", o_bus_err, 0);
    chk("rst_start", o_cpu_start, 0);
    repeat (2) @(negedge clk);
    i_rst_n = 1'b1;
    for (int i = 0; i < 256; i++) begin
      model_mem[i] = 16'($urandom);
      load(1'b1, 8'(i), model_mem[i], 1'b0);
    end
    model_mem[8'h30] = 16'h1111; load(1'b1, 8'h30, 16'h1111, 1'b0);
    model_mem[8'h00] = 16'h1234; load(1'b1, 8'h00, 16'h1234, 1'b0);
    @(negedge clk);
    i_rd_req = 1'b1; i_wr_req = 1'b1; i_memory_addr = 8'h40; i_memory_data = 16'h7777;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("load_phase_busy", o_busy, 0);
      chk("load_phase_ready", o_mem_ready, 0);
      chk("load_phase_err", o_bus_err, 0);
    end
    i_rd_req = 1'b0; i_wr_req = 1'b0;
    chk("start_before_done", o_cpu_start, 0);
    model_mem[8'hFF] = 16'hBEEF;
    load(1'b1, 8'hFF, 16'hBEEF, 1'b1);
    chk("start_after_done", o_cpu_start, 1);
    chk("start0_after_done", start0, 1);
    @(negedge clk);
    rd0 = 1'b1; i_memory_addr = 8'h00;
    @(negedge clk);
    rd0 = 1'b0;
    chk("w0_busy_k0", busy0, 1);
    chk("w0_ready_k0", ready0, 0);
    @(negedge clk);
    chk("w0_ready_k1", ready0, 1);
    chk("w0_busy_k1", busy0, 0);
    chk("w0_rdata", rdata0, 16'h1234);
    @(negedge clk);
    chk("w0_ready_k2", ready0, 0);
    load(1'b1, 8'h00, 16'hDEAD, 1'b1);
    chk("start_sticky", o_cpu_start, 1);
    for (int i = 0; i < 6; i++) begin
      do_txn(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data);
      chk("tbl_rdata", o_memory_data, tbl[i].exp_rdata);
    end
    for (int i = 0; i < 40; i++) begin
      int kind;
      logic [7:0] a;
      kind = int'($urandom_range(0, 2));
      a = 8'($urandom);
      if (a == 8'h30) a = 8'h31;
      do_txn(kind != 1, kind != 0, a, 16'($urandom));
    end
    @(negedge clk);
    i_wr_req = 1'b1; i_memory_addr = 8'h30; i_memory_data = 16'h9999;
    @(negedge clk);
    i_wr_req = 1'b0;
    chk("abort_busy_before", o_busy, 1);
    i_rst_n = 1'b0;
    model_rdata = 16'h0000;
    #1;
    chk("abort_busy", o_busy, 0);
    chk("abort_ready", o_mem_ready, 0);
    chk("abort_rdata", o_memory_data, 0);
    chk("abort_start", o_cpu_start, 0);
    chk("abort_err", o_bus_err, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_no_ready", o_mem_ready, 0);
    end
    i_rst_n = 1'b1;
    @(negedge clk);
    chk("abort_post_ready", o_mem_ready, 0);
    chk("abort_post_start", o_cpu_start, 0);
    load(1'b0, 8'h00, 16'h0000, 1'b1);
    chk("restart", o_cpu_start, 1);
    do_txn(1'b1, 1'b0, 8'h30, 16'h0000);
    chk("abort_kept", o_memory_data, 16'h1111);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
